// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the 2x2 systolic sequencer
package tpu_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam int N_ELEMS     = 8;
    localparam int FEED_CYCLES = 3;
    localparam int N_RESULTS   = 4;

endpackage

// File: rtl/systolic_2x2_controller.sv
// rtl/systolic_2x2_controller.sv - load, clear, skewed feed, drain and unload sequencer for a 2x2 systolic array
module systolic_2x2_controller
    import tpu_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 arr_rst,
    output logic                 arr_valid,
    output logic [WIDTH-1:0]     arr_a0,
    output logic [WIDTH-1:0]     arr_a1,
    output logic [WIDTH-1:0]     arr_b0,
    output logic [WIDTH-1:0]     arr_b1,
    input  logic [2*WIDTH-1:0]   arr_c00,
    input  logic [2*WIDTH-1:0]   arr_c01,
    input  logic [2*WIDTH-1:0]   arr_c10,
    input  logic [2*WIDTH-1:0]   arr_c11
);

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           idx;
    logic [1:0]           ridx;
    logic [7:0]           cnt;
    logic [WIDTH-1:0]     opnd [N_ELEMS];
    logic [2*WIDTH-1:0]   res  [N_RESULTS];

    logic                 in_accept;
    logic                 out_accept;
    logic                 feed_last;
    logic                 drain_last;
    logic [WIDTH-1:0]     feed_a0, feed_a1, feed_b0, feed_b1;

    assign in_ready   = (state == S_LOAD);
    assign out_valid  = (state == S_OUT);
    assign busy       = (state != S_LOAD);
    assign out_data   = res[ridx];
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign feed_last  = (state == S_FEED)  && (cnt == 8'(FEED_CYCLES - 1));
    // The extra DRAIN count is the capture cycle: by then the array has seen every drain beat.
    assign drain_last = (state == S_DRAIN) && (cnt == 8'(DRAIN_CYCLES));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // Next-state decode and the operand skew schedule (opnd: A00,A01,A10,A11,B00,B01,B10,B11)
    always_comb begin
        state_nxt = state;
        feed_a0   = '0;
        feed_a1   = '0;
        feed_b0   = '0;
        feed_b1   = '0;
        case (state)
            S_LOAD:  if (in_accept && idx == 3'd7)  state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (feed_last)                 state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last)                state_nxt = S_OUT;
            S_OUT:   if (out_accept && ridx == 2'd3) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
        if (state == S_FEED) begin
            case (cnt)
                8'd0: begin
                    feed_a0 = opnd[0];
                    feed_b0 = opnd[4];
                end
                8'd1: begin
                    feed_a0 = opnd[1];
                    feed_a1 = opnd[2];
                    feed_b0 = opnd[6];
                    feed_b1 = opnd[5];
                end
                8'd2: begin
                    feed_a1 = opnd[3];
                    feed_b1 = opnd[7];
                end
                default: ;
            endcase
        end
    end

    // Element, result-index and phase counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            ridx <= '0;
            cnt  <= '0;
        end else begin
            if (in_accept)  idx  <= idx + 3'd1;
            if (out_accept) ridx <= ridx + 2'd1;
            if ((state == S_FEED && !feed_last) || (state == S_DRAIN && !drain_last))
                cnt <= cnt + 8'd1;
            else
                cnt <= '0;
        end
    end

    // Operand capture during LOAD and result capture at the end of DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEMS; i++)   opnd[i] <= '0;
            for (int i = 0; i < N_RESULTS; i++) res[i]  <= '0;
        end else begin
            if (in_accept) opnd[idx] <= in_data;
            if (drain_last) begin
                res[0] <= arr_c00;
                res[1] <= arr_c01;
                res[2] <= arr_c10;
                res[3] <= arr_c11;
            end
        end
    end

    // Registered array drive and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_rst   <= 1'b0;
            arr_valid <= 1'b0;
            arr_a0    <= '0;
            arr_a1    <= '0;
            arr_b0    <= '0;
            arr_b1    <= '0;
            done      <= 1'b0;
        end else begin
            arr_rst   <= (state == S_CLEAR);
            arr_valid <= (state == S_FEED) || (state == S_DRAIN && !drain_last);
            arr_a0    <= feed_a0;
            arr_a1    <= feed_a1;
            arr_b0    <= feed_b0;
            arr_b1    <= feed_b1;
            done      <= out_accept && (ridx == 2'd3);
        end
    end

endmodule

// File: tb/tb_systolic_2x2_controller.sv
// tb/tb_systolic_2x2_controller.sv - self-checking bench for systolic_2x2_controller with a behavioural 2x2 array
module tb_systolic_2x2_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        arr_rst;
    logic        arr_valid;
    logic [7:0]  arr_a0, arr_a1, arr_b0, arr_b1;
    logic [15:0] arr_c00, arr_c01, arr_c10, arr_c11;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_edge = 0;
    logic [7:0]  ma [8];
    logic [15:0] exp_c [4];

    systolic_2x2_controller #(.WIDTH(8), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done),
        .arr_rst(arr_rst), .arr_valid(arr_valid),
        .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
        .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output-stationary 2x2 array: a moves right, b moves down, one register per hop
    logic [7:0] pa00, pb00, pa10, pb01;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || arr_rst) begin
            arr_c00 <= '0; arr_c01 <= '0; arr_c10 <= '0; arr_c11 <= '0;
            pa00 <= '0; pb00 <= '0; pa10 <= '0; pb01 <= '0;
        end else if (arr_valid) begin
            arr_c00 <= arr_c00 + 16'(arr_a0) * 16'(arr_b0);
            arr_c01 <= arr_c01 + 16'(pa00)   * 16'(arr_b1);
            arr_c10 <= arr_c10 + 16'(arr_a1) * 16'(pb00);
            arr_c11 <= arr_c11 + 16'(pa10)   * 16'(pb01);
            pa00 <= arr_a0; pb00 <= arr_b0; pa10 <= arr_a1; pb01 <= arr_b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // C = A x B from the loaded element order, wrapped to 16 bits
    task automatic compute_expected();
        int a [2][2];
        int b [2][2];
        for (int i = 0; i < 4; i++) begin
            a[i/2][i%2] = int'(ma[i]);
            b[i/2][i%2] = int'(ma[i+4]);
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp_c[i*2+j] = 16'((a[i][0]*b[0][j] + a[i][1]*b[1][j]) & 32'hFFFF);
    endtask

    task automatic rand_mats();
        for (int i = 0; i < 8; i++) ma[i] = 8'($urandom);
        compute_expected();
    endtask

    // Called and returns at a negedge
    task automatic load(input bit gaps);
        int i = 0;
        for (int g = 0; g < 200 && i < 8; g++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? ma[i] : 8'($urandom);
            if (in_valid && in_ready) begin
                i++;
                if (i == 8) acc_edge = cyc + 1;
            end
            @(negedge clk);
        end
        chk("load_complete", i, 8);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit hold, input bit stall, input bit rand_ready);
        int  k;
        bit  got = 0;
        logic [1:0]  e_ctl;
        logic [31:0] e_ops;
        for (int n = 0; n < 40 && !got; n++) begin
            k = cyc - acc_edge;
            in_valid = hold;
            in_data  = 8'($urandom);
            e_ctl = {1'(k == 1), 1'(k >= 2 && k <= 7)};
            e_ops = (k == 2) ? {ma[0], 8'd0,  ma[4], 8'd0 } :
                    (k == 3) ? {ma[1], ma[2], ma[6], ma[5]} :
                    (k == 4) ? {8'd0,  ma[3], 8'd0,  ma[7]} : 32'd0;
            chk("busy_in_ready", {in_ready, busy}, 2'b01);
            chk("trace_ctl", {arr_rst, arr_valid}, e_ctl);
            chk("trace_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, e_ops);
            if (out_valid) begin
                got = 1;
                chk("latency", k, 8);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk("out_valid_timeout", 0, 1);
        for (int r = 0; r < 4; r++) begin
            if (stall && r == 0) begin
                for (int s = 0; s < 5; s++) begin
                    out_ready = 1'b0;
                    in_valid  = hold;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, exp_c[0]);
                    @(negedge clk);
                end
            end
            for (int w = 0; w < 20; w++) begin
                out_ready = (rand_ready && w < 19) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid  = hold;
                in_data   = 8'($urandom);
                chk("out_valid", out_valid, 1);
                chk("out_data", out_data, exp_c[r]);
                chk("out_in_ready_done", {in_ready, done}, 2'b00);
                @(negedge clk);
                if (out_ready) break;
            end
        end
        chk("done_pulse", {done, in_ready, busy, out_valid}, 4'b1100);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("done_clear", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {in_ready, out_valid, busy, done, arr_rst, arr_valid}, 6'b100000);
        chk("reset_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
        chk("reset_out_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed product
        ma = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        compute_expected();
        chk("model_c00", exp_c[0], 19);
        load(0);
        collect(0, 0, 0);

        // All-ones operands, wrapped results
        for (int i = 0; i < 8; i++) ma[i] = 8'd255;
        compute_expected();
        chk("model_wrap", exp_c[3], 64514);
        load(0);
        collect(0, 0, 0);

        // Consumer stall on C00
        rand_mats();
        load(1);
        collect(0, 1, 0);

        // in_valid held high while busy, then a second matrix
        rand_mats();
        load(0);
        collect(1, 0, 0);
        rand_mats();
        load(0);
        collect(0, 0, 0);

        // Reset during FEED t1, then a fresh load
        rand_mats();
        load(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midreset_flags", {in_ready, out_valid, busy, done, arr_rst, arr_valid}, 6'b100000);
        chk("midreset_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
        chk("midreset_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_mats();
        load(0);
        collect(0, 0, 0);

        // Random matrices, random input gaps and output backpressure
        for (int t = 0; t < 6; t++) begin
            rand_mats();
            load(1);
            collect(1'(t % 2), 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
